// File: rtl/continuous_monitoring_system_pkg.sv
// Shared trace-stream definitions: field widths, packet bit locations, skid states and record types.
`default_nettype none

package continuous_monitoring_system_pkg;

  localparam int RISC_V_INSTRUCTION_WIDTH            = 32;
  localparam int XLEN                                = 32;
  localparam int CLK_COUNTER_WIDTH                   = 64;
  localparam int NO_OF_PERFORMANCE_EVENTS            = 4;
  localparam int PERFORMANCE_EVENT_MOD_COUNTER_WIDTH = 8;
  localparam int PERF_WIDTH = NO_OF_PERFORMANCE_EVENTS * PERFORMANCE_EVENT_MOD_COUNTER_WIDTH;

  // Bit positions shared by the transmitter and the receiver.
  localparam int PC_LOCATION                = PERF_WIDTH;
  localparam int CLK_COUNTER_DELTA_LOCATION = PC_LOCATION + XLEN;
  localparam int INSTR_LOCATION             = CLK_COUNTER_DELTA_LOCATION + CLK_COUNTER_WIDTH;
  localparam int AXI_DATA_WIDTH             = INSTR_LOCATION + RISC_V_INSTRUCTION_WIDTH;

  localparam logic [RISC_V_INSTRUCTION_WIDTH-1:0] WFI_INSTRUCTION = 32'h1050_0073;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
    logic [CLK_COUNTER_WIDTH-1:0]        delta;
    logic [XLEN-1:0]                     pc;
    logic [PERF_WIDTH-1:0]               perf;
  } trace_pkt_t;

  typedef struct packed {
    trace_pkt_t                   pkt;
    logic [CLK_COUNTER_WIDTH-1:0] timestamp;
    logic                         frame_end;
  } trace_rec_t;

  function automatic trace_pkt_t unpack_pkt(input logic [AXI_DATA_WIDTH-1:0] d);
    trace_pkt_t p;
    p.perf  = d[PC_LOCATION-1:0];
    p.pc    = d[CLK_COUNTER_DELTA_LOCATION-1:PC_LOCATION];
    p.delta = d[INSTR_LOCATION-1:CLK_COUNTER_DELTA_LOCATION];
    p.instr = d[AXI_DATA_WIDTH-1:INSTR_LOCATION];
    return p;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_skid_buffer.sv
// Two-entry full-throughput skid buffer; ready and valid are both registered.
`default_nettype none

module axis_skid_buffer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      r_state;
  logic [WIDTH-1:0] r_tail;
  logic             w_accept;
  logic             w_consume;

  assign w_accept  = in_valid & in_ready;
  assign w_consume = out_valid & out_ready;

  // out_data is the head entry; r_tail only holds data while FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SKID_EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      r_tail    <= '0;
    end else begin
      in_ready  <= 1'b1;
      out_valid <= 1'b1;
      case (r_state)
        SKID_EMPTY: begin
          out_valid <= w_accept;
          if (w_accept) begin
            out_data <= in_data;
            r_state  <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (w_accept && !w_consume) begin
            r_tail   <= in_data;
            r_state  <= SKID_FULL;
            in_ready <= 1'b0;
          end else if (!w_accept && w_consume) begin
            r_state   <= SKID_EMPTY;
            out_valid <= 1'b0;
          end else if (w_accept) begin
            out_data <= in_data;
          end
        end
        SKID_FULL: begin
          if (w_consume) begin
            out_data <= r_tail;
            r_state  <= SKID_ONE;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          r_state   <= SKID_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/cms_trace_receiver.sv
// AXI-Stream trace sink: decodes packets, rebuilds timestamps, checks frame length, keeps statistics.
`default_nettype none

module cms_trace_receiver
  import continuous_monitoring_system_pkg::*;
#(
  parameter int SKID_DEPTH      = 2,
  parameter bit CHECK_FRAME_LEN = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                S_AXIS_tvalid,
  output logic                                S_AXIS_tready,
  input  logic [AXI_DATA_WIDTH-1:0]           S_AXIS_tdata,
  input  logic                                S_AXIS_tlast,
  input  logic [31:0]                         tlast_interval,
  input  logic                                clear_stats,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [RISC_V_INSTRUCTION_WIDTH-1:0] out_instr,
  output logic [XLEN-1:0]                     out_pc,
  output logic [CLK_COUNTER_WIDTH-1:0]        out_delta,
  output logic [CLK_COUNTER_WIDTH-1:0]        out_timestamp,
  output logic [PERF_WIDTH-1:0]               out_perf,
  output logic                                out_frame_end,
  output logic [31:0]                         pkt_count,
  output logic [31:0]                         frame_count,
  output logic                                err_frame_len,
  output logic                                err_zero_delta
);

  if (SKID_DEPTH != 2) begin : g_depth_check
    $error("cms_trace_receiver: SKID_DEPTH must be 2");
  end

  logic                         w_accept;
  trace_pkt_t                   w_pkt;
  trace_rec_t                   w_in_rec;
  trace_rec_t                   w_out_rec;
  logic [CLK_COUNTER_WIDTH-1:0] r_ts_acc;
  logic [CLK_COUNTER_WIDTH-1:0] w_ts_base;
  logic [31:0]                  r_beat_cnt;
  logic [31:0]                  w_beat_base;
  logic [31:0]                  w_beat_next;
  logic [31:0]                  w_pkt_base;
  logic [31:0]                  w_frame_base;
  logic                         w_len_check;
  logic                         w_len_err;

  assign w_accept = S_AXIS_tvalid & S_AXIS_tready;
  assign w_pkt    = unpack_pkt(S_AXIS_tdata);

  // A clear coinciding with an accept makes that packet the first one after the clear.
  assign w_ts_base    = clear_stats ? '0 : r_ts_acc;
  assign w_beat_base  = clear_stats ? '0 : r_beat_cnt;
  assign w_pkt_base   = clear_stats ? '0 : pkt_count;
  assign w_frame_base = clear_stats ? '0 : frame_count;
  assign w_beat_next  = w_beat_base + 32'd1;

  assign w_len_check = CHECK_FRAME_LEN && (tlast_interval != 32'd0);
  assign w_len_err   = w_accept && w_len_check &&
                       (S_AXIS_tlast ? ((w_beat_next != tlast_interval) && (w_pkt.instr != WFI_INSTRUCTION))
                                     : (w_beat_next == tlast_interval));

  always_comb begin
    w_in_rec           = '0;
    w_in_rec.pkt       = w_pkt;
    w_in_rec.timestamp = w_ts_base + w_pkt.delta;
    w_in_rec.frame_end = S_AXIS_tlast;
  end

  axis_skid_buffer #(
    .WIDTH($bits(trace_rec_t))
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (S_AXIS_tvalid),
    .in_ready (S_AXIS_tready),
    .in_data  (w_in_rec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (w_out_rec)
  );

  assign out_instr     = w_out_rec.pkt.instr;
  assign out_pc        = w_out_rec.pkt.pc;
  assign out_delta     = w_out_rec.pkt.delta;
  assign out_perf      = w_out_rec.pkt.perf;
  assign out_timestamp = w_out_rec.timestamp;
  assign out_frame_end = w_out_rec.frame_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts_acc       <= '0;
      r_beat_cnt     <= '0;
      pkt_count      <= '0;
      frame_count    <= '0;
      err_frame_len  <= 1'b0;
      err_zero_delta <= 1'b0;
    end else begin
      r_ts_acc       <= w_accept ? w_in_rec.timestamp : w_ts_base;
      r_beat_cnt     <= w_accept ? (S_AXIS_tlast ? 32'd0 : w_beat_next) : w_beat_base;
      pkt_count      <= w_accept ? sat_inc(w_pkt_base) : w_pkt_base;
      frame_count    <= (w_accept && S_AXIS_tlast) ? sat_inc(w_frame_base) : w_frame_base;
      err_frame_len  <= (err_frame_len & ~clear_stats) | w_len_err;
      err_zero_delta <= (err_zero_delta & ~clear_stats) |
                        (w_accept && (w_pkt.delta == '0));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cms_trace_receiver.sv
// Directed self-checking bench for cms_trace_receiver.
`default_nettype none

module tb_cms_trace_receiver;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] WFI = 32'h1050_0073;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         S_AXIS_tvalid = 1'b0;
  logic         S_AXIS_tready;
  logic [159:0] S_AXIS_tdata = '0;
  logic         S_AXIS_tlast = 1'b0;
  logic [31:0]  tlast_interval = 32'd0;
  logic         clear_stats = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_instr;
  logic [31:0]  out_pc;
  logic [63:0]  out_delta;
  logic [63:0]  out_timestamp;
  logic [31:0]  out_perf;
  logic         out_frame_end;
  logic [31:0]  pkt_count;
  logic [31:0]  frame_count;
  logic         err_frame_len;
  logic         err_zero_delta;

  int vectors = 0;
  int miscompares = 0;

  cms_trace_receiver #(
    .SKID_DEPTH(2),
    .CHECK_FRAME_LEN(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tlast(S_AXIS_tlast),
    .tlast_interval(tlast_interval), .clear_stats(clear_stats),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_delta(out_delta),
    .out_timestamp(out_timestamp), .out_perf(out_perf), .out_frame_end(out_frame_end),
    .pkt_count(pkt_count), .frame_count(frame_count),
    .err_frame_len(err_frame_len), .err_zero_delta(err_zero_delta)
  );

  always #5 clk = ~clk;

  // Layout from LSB: perf, pc, delta, instr.
  function automatic logic [159:0] mk(input logic [31:0] instr, input logic [63:0] delta,
                                      input logic [31:0] pc, input logic [31:0] perf);
    return {instr, delta, pc, perf};
  endfunction

  // One beat presented for exactly one clock edge; acc reports whether it was taken.
  task automatic drive_beat(input logic [31:0] instr, input logic [63:0] delta, input logic [31:0] pc,
                            input logic last, input logic clr, output logic acc);
    @(negedge clk);
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = mk(instr, delta, pc, pc ^ 32'hA5A5_0000);
    S_AXIS_tlast  = last;
    clear_stats   = clr;
    acc           = S_AXIS_tready;
    @(posedge clk);
    #1;
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tlast  = 1'b0;
    clear_stats   = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (S_AXIS_tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready: got %b expected 0", S_AXIS_tready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (pkt_count !== 32'd0 || frame_count !== 32'd0) begin miscompares++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", pkt_count, frame_count); end
    vectors++; if (out_timestamp !== 64'd0 || err_frame_len !== 1'b0 || err_zero_delta !== 1'b0) begin miscompares++; $display("FAIL reset_data: got ts %0h errs %b%b expected 0", out_timestamp, err_frame_len, err_zero_delta); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++; if (S_AXIS_tready !== 1'b1) begin miscompares++; $display("FAIL release_tready: got %b expected 1", S_AXIS_tready); end
  endtask

  task automatic test_stream();
    logic [63:0] deltas [3] = '{64'd5, 64'd7, 64'd1};
    logic [63:0] exp_ts [3] = '{64'd5, 64'd12, 64'd13};
    logic acc;
    out_ready = 1'b1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_idle_valid: got %b expected 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      drive_beat(NOP, deltas[i], 32'h8000_0000 + 32'(4 * i), 1'b0, 1'b0, acc);
      vectors++; if (acc !== 1'b1 || out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got acc %b valid %b expected 1 1", i, acc, out_valid); end
      vectors++; if (out_timestamp !== exp_ts[i]) begin miscompares++; $display("FAIL stream_ts[%0d]: got %0d expected %0d", i, out_timestamp, exp_ts[i]); end
      vectors++; if (out_pc !== 32'h8000_0000 + 32'(4 * i) || out_delta !== deltas[i]) begin miscompares++; $display("FAIL stream_fields[%0d]: got pc %h delta %0d", i, out_pc, out_delta); end
      vectors++; if (out_perf !== ((32'h8000_0000 + 32'(4 * i)) ^ 32'hA5A5_0000) || out_instr !== NOP) begin miscompares++; $display("FAIL stream_perf[%0d]: got perf %h instr %h", i, out_perf, out_instr); end
    end
    @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain: got valid %b expected 0", out_valid); end
    vectors++; if (pkt_count !== 32'd3) begin miscompares++; $display("FAIL stream_pkt_count: got %0d expected 3", pkt_count); end
  endtask

  task automatic test_back_to_back();
    logic acc;
    int naccepted = 0;
    int got = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(NOP, 64'd1, 32'h100 + 32'(i), 1'b0, 1'b0, acc);
      if (acc) naccepted++;
      if (i == 1) begin
        vectors++; if (S_AXIS_tready !== 1'b0) begin miscompares++; $display("FAIL bp_tready_after_2nd: got %b expected 0", S_AXIS_tready); end
      end
    end
    vectors++; if (naccepted != 2) begin miscompares++; $display("FAIL bp_accepted: got %0d expected 2", naccepted); end
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_timestamp !== 64'd14) begin miscompares++; $display("FAIL bp_hold: got valid %b pc %h ts %0d expected 1 100 14", out_valid, out_pc, out_timestamp); end
    @(negedge clk);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (out_valid) begin
        vectors++; if (out_pc !== 32'h100 + 32'(got)) begin miscompares++; $display("FAIL bp_order[%0d]: got pc %h expected %h", got, out_pc, 32'h100 + 32'(got)); end
        got++;
      end
      @(posedge clk);
      #1;
    end
    vectors++; if (got != 2) begin miscompares++; $display("FAIL bp_drain_count: got %0d expected 2", got); end
    vectors++; if (pkt_count !== 32'd5) begin miscompares++; $display("FAIL bp_pkt_count: got %0d expected 5", pkt_count); end
  endtask

  task automatic test_frame_len();
    logic acc;
    pulse_clear();
    tlast_interval = 32'd4;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) drive_beat(NOP, 64'd1, 32'h200 + 32'(i), (i % 4) == 3, 1'b0, acc);
    vectors++; if (err_frame_len !== 1'b0) begin miscompares++; $display("FAIL frame_ok_err: got %b expected 0", err_frame_len); end
    vectors++; if (frame_count !== 32'd2) begin miscompares++; $display("FAIL frame_ok_count: got %0d expected 2", frame_count); end
    vectors++; if (out_frame_end !== 1'b1) begin miscompares++; $display("FAIL frame_end_flag: got %b expected 1", out_frame_end); end
    for (int i = 0; i < 3; i++) drive_beat(NOP, 64'd1, 32'h300 + 32'(i), i == 2, 1'b0, acc);
    vectors++; if (err_frame_len !== 1'b1) begin miscompares++; $display("FAIL frame_short_err: got %b expected 1", err_frame_len); end
    vectors++; if (frame_count !== 32'd3) begin miscompares++; $display("FAIL frame_short_count: got %0d expected 3", frame_count); end
  endtask

  task automatic test_wfi();
    logic acc;
    pulse_clear();
    vectors++; if (err_frame_len !== 1'b0 || frame_count !== 32'd0) begin miscompares++; $display("FAIL wfi_clear: got err %b frames %0d expected 0 0", err_frame_len, frame_count); end
    tlast_interval = 32'd4;
    drive_beat(NOP, 64'd1, 32'h400, 1'b0, 1'b0, acc);
    drive_beat(WFI, 64'd1, 32'h404, 1'b1, 1'b0, acc);
    vectors++; if (err_frame_len !== 1'b0) begin miscompares++; $display("FAIL wfi_err: got %b expected 0", err_frame_len); end
    vectors++; if (frame_count !== 32'd1) begin miscompares++; $display("FAIL wfi_count: got %0d expected 1", frame_count); end
    vectors++; if (out_instr !== WFI || out_frame_end !== 1'b1) begin miscompares++; $display("FAIL wfi_record: got instr %h end %b", out_instr, out_frame_end); end
  endtask

  task automatic test_wrap_and_clear();
    logic acc;
    pulse_clear();
    tlast_interval = 32'd1;
    drive_beat(NOP, 64'hFFFF_FFFF_FFFF_FFFD, 32'h500, 1'b0, 1'b0, acc);
    vectors++; if (out_timestamp !== 64'hFFFF_FFFF_FFFF_FFFD) begin miscompares++; $display("FAIL wrap_pre: got %h expected fffffffffffffffd", out_timestamp); end
    vectors++; if (err_frame_len !== 1'b1) begin miscompares++; $display("FAIL interval_no_tlast: got %b expected 1", err_frame_len); end
    tlast_interval = 32'd0;
    drive_beat(NOP, 64'd5, 32'h504, 1'b0, 1'b0, acc);
    vectors++; if (out_timestamp !== 64'd2) begin miscompares++; $display("FAIL wrap_ts: got %0d expected 2", out_timestamp); end
    vectors++; if (err_zero_delta !== 1'b0) begin miscompares++; $display("FAIL zero_delta_early: got %b expected 0", err_zero_delta); end
    drive_beat(NOP, 64'd0, 32'h508, 1'b0, 1'b0, acc);
    vectors++; if (err_zero_delta !== 1'b1) begin miscompares++; $display("FAIL zero_delta: got %b expected 1", err_zero_delta); end
    pulse_clear();
    vectors++; if (err_zero_delta !== 1'b0 || err_frame_len !== 1'b0) begin miscompares++; $display("FAIL clear_errs: got %b%b expected 00", err_frame_len, err_zero_delta); end
    vectors++; if (pkt_count !== 32'd0) begin miscompares++; $display("FAIL clear_pkt_count: got %0d expected 0", pkt_count); end
    drive_beat(NOP, 64'd9, 32'h50C, 1'b0, 1'b1, acc);
    vectors++; if (pkt_count !== 32'd1 || out_timestamp !== 64'd9) begin miscompares++; $display("FAIL clear_with_accept: got cnt %0d ts %0d expected 1 9", pkt_count, out_timestamp); end
  endtask

  task automatic test_reset_full();
    logic acc;
    out_ready = 1'b0;
    drive_beat(NOP, 64'd3, 32'h600, 1'b0, 1'b0, acc);
    drive_beat(NOP, 64'd3, 32'h604, 1'b1, 1'b0, acc);
    vectors++; if (S_AXIS_tready !== 1'b0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL full_before_rst: got tready %b valid %b expected 0 1", S_AXIS_tready, out_valid); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0 || S_AXIS_tready !== 1'b0) begin miscompares++; $display("FAIL async_rst: got valid %b tready %b expected 0 0", out_valid, S_AXIS_tready); end
    vectors++; if (pkt_count !== 32'd0 || frame_count !== 32'd0) begin miscompares++; $display("FAIL async_rst_counts: got %0d/%0d expected 0/0", pkt_count, frame_count); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (S_AXIS_tready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL post_rst: got tready %b valid %b expected 1 0", S_AXIS_tready, out_valid); end
    vectors++; if (pkt_count !== 32'd0 || out_timestamp !== 64'd0) begin miscompares++; $display("FAIL post_rst_state: got cnt %0d ts %0d expected 0 0", pkt_count, out_timestamp); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_frame_len();
    test_wfi();
    test_wrap_and_clear();
    test_reset_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/cms_trace_receiver.md
Name: cms_trace_receiver

Overview:
AXI-Stream slave that terminates the trace stream produced by the continuous monitoring system. It accepts trace packets and unpacks them into instruction, PC, clock delta and performance-event counter fields. It rebuilds absolute timestamps, checks frame (tlast) integrity and keeps statistics. It is used as the on-chip consumer in simulation and loopback builds, and as a pre-DMA checker in hardware.

Parameters:
- SKID_DEPTH, 2, input buffer depth in packets; fixed at 2, a full-throughput skid buffer.
- CHECK_FRAME_LEN, 1, 1 enables the tlast-interval check; 0 disables it.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- S_AXIS_tvalid  in  1  packet valid
- S_AXIS_tready  out  1  receiver can accept a packet
- S_AXIS_tdata  in  AXI_DATA_WIDTH  packed trace packet
- S_AXIS_tlast  in  1  frame end
- tlast_interval  in  32  expected beats per frame; 0 means no interval
- clear_stats  in  1  synchronous pulse that clears counters and sticky errors
- out_valid  out  1  decoded record valid
- out_ready  in  1  downstream accepts record
- out_instr  out  RISC_V_INSTRUCTION_WIDTH  decoded instruction
- out_pc  out  XLEN  decoded PC
- out_delta  out  CLK_COUNTER_WIDTH  raw clock delta
- out_timestamp  out  CLK_COUNTER_WIDTH  reconstructed absolute timestamp
- out_perf  out  NO_OF_PERFORMANCE_EVENTS*PERFORMANCE_EVENT_MOD_COUNTER_WIDTH  counter field, copied bit-for-bit
- out_frame_end  out  1  record was the tlast beat
- pkt_count  out  32  packets accepted
- frame_count  out  32  tlast beats accepted
- err_frame_len  out  1  sticky: frame length mismatch
- err_zero_delta  out  1  sticky: a packet carried delta == 0

Behaviour:
- Reset (async, active-high): buffer empty, out_valid=0, S_AXIS_tready=0 during reset and 1 on the first clk after release. All data outputs, counts, timestamp accumulator, beat counter and errors are 0.
- Packet layout, from LSB upward:
  - the performance counter field (counter[0] in the most-significant slot of the field),
  - PC at PC_LOCATION,
  - delta at CLK_COUNTER_DELTA_LOCATION,
  - instr at INSTR_LOCATION.
- Handshake: a beat is accepted when S_AXIS_tvalid & S_AXIS_tready. A record is consumed when out_valid & out_ready. out_* must stay stable while out_valid & ~out_ready.
- Skid FSM has three states:
  - EMPTY: on accept, go to ONE.
  - ONE: accept without consume -> FULL; consume without accept -> EMPTY; both at once -> stay ONE.
  - FULL: consume -> ONE. Accept is impossible here.
- S_AXIS_tready is registered, equal to (state != FULL), so it has no combinational path from out_ready.
- Latency: a beat accepted at edge N produces out_valid at N+1. With out_ready held at 1, throughput is 1 packet/cycle.
- Decode and timestamp are computed at accept time and stored in the buffer entry.
  - timestamp_acc <= timestamp_acc + delta, modulo 2^CLK_COUNTER_WIDTH (wraps silently).
  - out_timestamp is the accumulated value including that packet's delta.
- Frame check:
  - beat_cnt counts accepted beats in the current frame, starting at 1.
  - On an accepted tlast: if CHECK_FRAME_LEN, tlast_interval != 0, beat_cnt != tlast_interval and instr != WFI_INSTRUCTION, set err_frame_len. Then beat_cnt returns to 0.
  - If beat_cnt reaches tlast_interval without tlast and the interval is nonzero, set err_frame_len.
  - A tlast on a WFI packet is always legal, whatever its length.
- err_zero_delta is set on any accepted packet whose delta is 0.
- pkt_count increments on every accept and saturates at 2^32-1. frame_count does the same on accepted tlast beats.
- clear_stats clears counts, errors, timestamp_acc and beat_cnt. If it coincides with an accept, that packet counts as the first after the clear: pkt_count=1, timestamp=delta.
- Reset mid-frame discards buffered packets. No partial-state recovery is required.

Decomposition:
- Add the following to continuous_monitoring_system_pkg: the skid-state enum type, and a trace_pkt_t struct (instr, delta, pc, perf).
- The *_LOCATION constants move out of the transmitter into the package so both ends share them.
- One sub-module, axis_skid_buffer, parameterised by width. It holds the two-entry FSM; the receiver does decode and stats around it.

Test Plan:
- Reset, then send 3 packets (delta=5, 7, 1; pc=0x80000000/4/8) with out_ready=1 -> out_timestamp 5, 12, 13; pkt_count=3; each out_valid appears 1 cycle after accept.
- Hold out_ready=0 and stream 4 beats -> exactly 2 accepted, S_AXIS_tready=0 from the cycle after the 2nd accept. Release out_ready -> records come out in order with no loss or duplicate.
- tlast_interval=4; frames of 4 beats with tlast on the 4th -> no error, frame_count=2. Then tlast on beat 3 with a non-WFI instr -> err_frame_len=1.
- tlast_interval=4, tlast on beat 2 with instr=WFI_INSTRUCTION -> err_frame_len stays 0, frame_count increments.
- timestamp_acc=2^64-3 (via deltas), next delta=5 -> out_timestamp=2. A delta=0 packet -> err_zero_delta=1. clear_stats -> both errors and pkt_count=0.
- Assert rst with a FULL buffer -> out_valid=0 and S_AXIS_tready=0 immediately (async). After release: tready=1, counts=0.
